// File: rtl/regfile_wport_arbiter_if.sv
// Write-port bundle between writeback, the auxiliary writer and the register file.
// Handshake: an aux transfer happens on a rising clock edge where aux_valid && aux_ready;
// aux_ready never depends combinationally on aux_valid; core_we is a one-cycle request
// that is ignored (not queued) while core_stall is high.
interface regfile_wport_arbiter_if;
  logic        core_we;
  logic [4:0]  core_waddr;
  logic [31:0] core_wdata;
  logic        core_stall;

  logic        aux_valid;
  logic        aux_ready;
  logic [4:0]  aux_waddr;
  logic [31:0] aux_wdata;

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  modport master (
    output core_we, core_waddr, core_wdata,
    output aux_valid, aux_waddr, aux_wdata,
    input  core_stall, aux_ready,
    input  rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  core_we, core_waddr, core_wdata,
    input  aux_valid, aux_waddr, aux_wdata,
    output core_stall, aux_ready,
    output rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/regfile_wport_arbiter.sv
// Register-file write-port arbiter: core writeback has priority, aux writes queue in a FIFO
// and a starvation timer forces one core stall slot. Optional macro: SCOREBOARD_EN.
module regfile_wport_arbiter #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    regfile_wport_arbiter_if.slave   wp,
    output logic [$clog2(DEPTH):0]   fifo_count,
    input  logic [4:0]               rs,
    input  logic [4:0]               rt,
    output logic                     rs_pending,
    output logic                     rt_pending
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(MAX_WAIT) + 1;

    logic [4:0]       q_addr [DEPTH];
    logic [31:0]      q_data [DEPTH];
    logic [DEPTH-1:0] q_valid;
    logic [DEPTH-1:0] valid_nxt;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count_q;
    logic [SW-1:0]    starve_q;
    logic             stall_q;

    logic full;
    logic empty;
    logic head_valid;
    logic core_grant;
    logic head_grant;
    logic pop;
    logic push;
    logic store;
    logic blocked;

    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign head_valid = !empty && q_valid[rd_ptr];

    // Both grants are suppressed while reset is asserted so no write leaks out in that cycle.
    assign core_grant = reset && !stall_q && wp.core_we && (wp.core_waddr != 5'd0);
    assign head_grant = reset && !core_grant && head_valid;
    // An invalidated head is retired immediately, even while the core holds the port.
    assign pop        = !empty && (head_grant || !q_valid[rd_ptr]);
    assign push       = wp.aux_valid && !full;
    assign store      = push && (wp.aux_waddr != 5'd0);
    assign blocked    = head_valid && !pop;

    assign wp.aux_ready  = !full;
    assign wp.core_stall = stall_q;
    assign fifo_count    = count_q;

    always_comb begin
        wp.rf_we    = 1'b0;
        wp.rf_waddr = 5'd0;
        wp.rf_wdata = 32'd0;
        if (core_grant) begin
            wp.rf_we    = 1'b1;
            wp.rf_waddr = wp.core_waddr;
            wp.rf_wdata = wp.core_wdata;
        end else if (head_grant) begin
            wp.rf_we    = 1'b1;
            wp.rf_waddr = q_addr[rd_ptr];
            wp.rf_wdata = q_data[rd_ptr];
        end
    end

    // A granted core write is newer than any queued write to the same register.
    always_comb begin
        valid_nxt = q_valid;
        for (int i = 0; i < DEPTH; i++) begin
            if (core_grant && (q_addr[i] == wp.core_waddr)) valid_nxt[i] = 1'b0;
        end
        if (pop)   valid_nxt[rd_ptr] = 1'b0;
        if (store) valid_nxt[wr_ptr] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            q_valid  <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count_q  <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            q_valid <= valid_nxt;
            if (pop)   rd_ptr <= rd_ptr + PW'(1);
            if (store) wr_ptr <= wr_ptr + PW'(1);
            count_q <= count_q + CW'(store) - CW'(pop);
            if (pop || empty)    starve_q <= '0;
            else if (head_valid) starve_q <= starve_q + SW'(1);
            stall_q <= blocked && (starve_q == SW'(MAX_WAIT - 1));
        end
    end

    always_ff @(posedge clock) begin
        if (store) begin
            q_addr[wr_ptr] <= wp.aux_waddr;
            q_data[wr_ptr] <= wp.aux_wdata;
        end
    end

`ifdef SCOREBOARD_EN
    always_comb begin
        rs_pending = 1'b0;
        rt_pending = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_valid[i] && (q_addr[i] == rs)) rs_pending = 1'b1;
            if (q_valid[i] && (q_addr[i] == rt)) rt_pending = 1'b1;
        end
        if (rs == 5'd0) rs_pending = 1'b0;
        if (rt == 5'd0) rt_pending = 1'b0;
    end
`else
    logic unused_sb;
    assign unused_sb  = ^{rs, rt};
    assign rs_pending = 1'b0;
    assign rt_pending = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Bench for regfile_wport_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the write-port rules.
module tb_regfile_wport_arbiter;
  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 8;
  localparam int CW       = $clog2(DEPTH) + 1;
`ifdef SCOREBOARD_EN
  localparam bit SB_EN = 1'b1;
`else
  localparam bit SB_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [CW-1:0] fifo_count;
  logic [4:0]    rs = 5'd0;
  logic [4:0]    rt = 5'd0;
  logic          rs_pending;
  logic          rt_pending;

  regfile_wport_arbiter_if wp();

  regfile_wport_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clock      (clock),
    .reset      (reset),
    .wp         (wp),
    .fifo_count (fifo_count),
    .rs         (rs),
    .rt         (rt),
    .rs_pending (rs_pending),
    .rt_pending (rt_pending)
  );

  // clock / reset
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // reference model: queued aux writes in arrival order
  logic [4:0]  m_addr[$];
  logic [31:0] exp_q[$];
  bit          m_val[$];
  bit          m_stall = 1'b0;
  int          m_wait  = 0;

  logic        e_rf_we, e_ready, e_stall, e_rsp, e_rtp;
  logic [4:0]  e_rf_waddr;
  logic [31:0] e_rf_wdata;
  int          e_count;

  task automatic model_eval();
    bit core_win;
    core_win   = reset && !m_stall && wp.core_we && (wp.core_waddr != 5'd0);
    e_ready    = (m_addr.size() < DEPTH);
    e_stall    = m_stall;
    e_count    = m_addr.size();
    e_rf_we    = 1'b0;
    e_rf_waddr = 5'd0;
    e_rf_wdata = 32'd0;
    if (core_win) begin
      e_rf_we = 1'b1; e_rf_waddr = wp.core_waddr; e_rf_wdata = wp.core_wdata;
    end else if (reset && m_addr.size() > 0 && m_val[0]) begin
      e_rf_we = 1'b1; e_rf_waddr = m_addr[0]; e_rf_wdata = exp_q[0];
    end
    e_rsp = 1'b0;
    e_rtp = 1'b0;
    if (SB_EN) begin
      foreach (m_addr[i]) begin
        if (m_val[i] && m_addr[i] == rs && rs != 5'd0) e_rsp = 1'b1;
        if (m_val[i] && m_addr[i] == rt && rt != 5'd0) e_rtp = 1'b1;
      end
    end
  endtask

  task automatic model_commit();
    bit core_win, head_ok, pop_it, new_stall;
    int size;
    if (!reset) begin
      m_addr.delete(); exp_q.delete(); m_val.delete();
      m_stall = 1'b0; m_wait = 0;
      return;
    end
    size      = m_addr.size();
    core_win  = !m_stall && wp.core_we && (wp.core_waddr != 5'd0);
    head_ok   = (size > 0) && m_val[0];
    pop_it    = (size > 0) && (!m_val[0] || !core_win);
    new_stall = head_ok && !pop_it && (m_wait == MAX_WAIT - 1);
    if (pop_it || size == 0) m_wait = 0;
    else if (head_ok)        m_wait++;
    if (core_win) foreach (m_addr[i]) if (m_addr[i] == wp.core_waddr) m_val[i] = 1'b0;
    if (pop_it) begin
      void'(m_addr.pop_front()); void'(exp_q.pop_front()); void'(m_val.pop_front());
    end
    if (wp.aux_valid && size < DEPTH && wp.aux_waddr != 5'd0) begin
      m_addr.push_back(wp.aux_waddr); exp_q.push_back(wp.aux_wdata); m_val.push_back(1'b1);
    end
    m_stall = new_stall;
  endtask

  // driver tasks
  task automatic set_in(input bit cwe, input logic [4:0] ca, input logic [31:0] cd,
                        input bit av, input logic [4:0] aa, input logic [31:0] ad);
    wp.core_we = cwe; wp.core_waddr = ca; wp.core_wdata = cd;
    wp.aux_valid = av; wp.aux_waddr = aa; wp.aux_wdata = ad;
    #1;
  endtask

  task automatic step();
    @(posedge clock);
    model_commit();
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    step(); step();
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
    checks++; if (fifo_count !== 0) begin errors++; $display("FAIL por_count got %0d want 0", fifo_count); end
    checks++; if (wp.aux_ready !== 1'b1) begin errors++; $display("FAIL por_ready got %0b want 1", wp.aux_ready); end
    for (int i = 0; i < 3; i++) begin
      set_in(1, 5'd31, 32'hC0DE, 1, 5'(i + 1), 32'(i));
      step();
    end
    set_in(0, 0, 0, 0, 0, 0);
    checks++; if (fifo_count !== 3) begin errors++; $display("FAIL midq_count got %0d want 3", fifo_count); end
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    checks++; if (wp.rf_we !== 1'b0) begin errors++; $display("FAIL rst_cycle_we got %0b want 0", wp.rf_we); end
    step(); step();
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
    checks++; if (fifo_count !== 0) begin errors++; $display("FAIL rst_count got %0d want 0", fifo_count); end
    checks++; if (wp.rf_we !== 1'b0) begin errors++; $display("FAIL rst_we got %0b want 0", wp.rf_we); end
    checks++; if (wp.aux_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %0b want 1", wp.aux_ready); end
    checks++; if (wp.core_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %0b want 0", wp.core_stall); end
    checks++; if (wp.rf_waddr !== 5'd0 || wp.rf_wdata !== 32'd0) begin
      errors++; $display("FAIL rst_rf_bus got %0d/%h want 0/0", wp.rf_waddr, wp.rf_wdata); end
  endtask

  task automatic test_single_push();
    set_in(0, 0, 0, 1, 5'd5, 32'h11);
    checks++; if (wp.rf_we !== 1'b0) begin errors++; $display("FAIL push_latency got %0b want 0", wp.rf_we); end
    step();
    set_in(0, 0, 0, 0, 0, 0);
    checks++; if (wp.rf_we !== 1'b1 || wp.rf_waddr !== 5'd5 || wp.rf_wdata !== 32'h11) begin
      errors++; $display("FAIL push_write got %0b/%0d/%h want 1/5/11", wp.rf_we, wp.rf_waddr, wp.rf_wdata); end
    checks++; if (fifo_count !== 1) begin errors++; $display("FAIL push_count got %0d want 1", fifo_count); end
    step();
    checks++; if (fifo_count !== 0) begin errors++; $display("FAIL push_drain got %0d want 0", fifo_count); end
  endtask

  task automatic test_starvation();
    set_in(1, 5'd3, 32'h300, 1, 5'd7, 32'h77);
    step();
    for (int i = 1; i <= MAX_WAIT; i++) begin
      set_in(1, 5'd3, 32'(32'h300 + i), 0, 0, 0);
      checks++; if (wp.core_stall !== 1'b0 || wp.rf_waddr !== 5'd3) begin
        errors++; $display("FAIL starve_core_%0d got stall=%0b addr=%0d want 0/3", i, wp.core_stall, wp.rf_waddr); end
      step();
    end
    set_in(1, 5'd3, 32'h3FF, 0, 0, 0);
    checks++; if (wp.core_stall !== 1'b1 || wp.rf_waddr !== 5'd7 || wp.rf_wdata !== 32'h77) begin
      errors++; $display("FAIL starve_slot got stall=%0b addr=%0d data=%h want 1/7/77",
                         wp.core_stall, wp.rf_waddr, wp.rf_wdata); end
    step();
    checks++; if (wp.core_stall !== 1'b0 || wp.rf_waddr !== 5'd3 || fifo_count !== 0) begin
      errors++; $display("FAIL starve_after got stall=%0b addr=%0d count=%0d want 0/3/0",
                         wp.core_stall, wp.rf_waddr, fifo_count); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      set_in(1, 5'd31, 32'h1, 1, 5'(10 + i), 32'(32'hA0 + i));
      step();
    end
    set_in(0, 0, 0, 1, 5'd14, 32'hA4);
    checks++; if (fifo_count !== 4 || wp.aux_ready !== 1'b0) begin
      errors++; $display("FAIL full got count=%0d ready=%0b want 4/0", fifo_count, wp.aux_ready); end
    checks++; if (wp.rf_waddr !== 5'd10) begin errors++; $display("FAIL full_pop got %0d want 10", wp.rf_waddr); end
    step();
    set_in(0, 0, 0, 1, 5'd14, 32'hA4);
    checks++; if (wp.rf_waddr !== 5'd11 || wp.aux_ready !== 1'b1) begin
      errors++; $display("FAIL pushpop got addr=%0d ready=%0b want 11/1", wp.rf_waddr, wp.aux_ready); end
    step();
    set_in(1, 5'd31, 32'h1, 1, 5'd0, 32'hDEAD);
    checks++; if (fifo_count !== 3) begin errors++; $display("FAIL pushpop_count got %0d want 3", fifo_count); end
    step();
    set_in(0, 0, 0, 0, 0, 0);
    checks++; if (fifo_count !== 3) begin errors++; $display("FAIL zero_addr_count got %0d want 3", fifo_count); end
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 0, 0);
      checks++; if (wp.rf_we !== 1'b1 || wp.rf_waddr !== 5'(12 + i)) begin
        errors++; $display("FAIL drain_%0d got %0b/%0d want 1/%0d", i, wp.rf_we, wp.rf_waddr, 12 + i); end
      step();
    end
    checks++; if (fifo_count !== 0) begin errors++; $display("FAIL drain_count got %0d want 0", fifo_count); end
  endtask

  task automatic test_invalidate();
    set_in(0, 0, 0, 1, 5'd9, 32'hA);
    step();
    set_in(1, 5'd9, 32'hB, 0, 0, 0);
    checks++; if (wp.rf_waddr !== 5'd9 || wp.rf_wdata !== 32'hB) begin
      errors++; $display("FAIL inval_core got %0d/%h want 9/b", wp.rf_waddr, wp.rf_wdata); end
    step();
    set_in(0, 0, 0, 0, 0, 0);
    checks++; if (wp.rf_we !== 1'b0 || fifo_count !== 1) begin
      errors++; $display("FAIL inval_drop got we=%0b count=%0d want 0/1", wp.rf_we, fifo_count); end
    step();
    checks++; if (wp.rf_we !== 1'b0 || fifo_count !== 0) begin
      errors++; $display("FAIL inval_empty got we=%0b count=%0d want 0/0", wp.rf_we, fifo_count); end
  endtask

  task automatic test_scoreboard();
    rs = 5'd4; rt = 5'd0;
    set_in(1, 5'd31, 32'h1, 1, 5'd4, 32'h44);
    checks++; if (rs_pending !== 1'b0) begin errors++; $display("FAIL sb_before got %0b want 0", rs_pending); end
    step();
    set_in(1, 5'd31, 32'h1, 0, 0, 0);
    checks++; if (rs_pending !== SB_EN || rt_pending !== 1'b0) begin
      errors++; $display("FAIL sb_pending got %0b/%0b want %0b/0", rs_pending, rt_pending, SB_EN); end
    step();
    set_in(0, 0, 0, 0, 0, 0);
    checks++; if (wp.rf_waddr !== 5'd4) begin errors++; $display("FAIL sb_pop got %0d want 4", wp.rf_waddr); end
    step();
    checks++; if (rs_pending !== 1'b0) begin errors++; $display("FAIL sb_after got %0b want 0", rs_pending); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 79) != 0);
      rs = 5'($urandom_range(0, 7));
      rt = 5'($urandom_range(0, 7));
      set_in($urandom_range(0, 3) != 0 || n < 200 ? ($urandom_range(0, 9) != 0) : 1'b0,
             5'($urandom_range(0, 7)), $urandom,
             $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
      model_eval();
      checks++; if (wp.rf_we !== e_rf_we || wp.rf_waddr !== e_rf_waddr || wp.rf_wdata !== e_rf_wdata) begin
        errors++; $display("FAIL rnd_rf cyc %0d got %0b/%0d/%h want %0b/%0d/%h", n,
                           wp.rf_we, wp.rf_waddr, wp.rf_wdata, e_rf_we, e_rf_waddr, e_rf_wdata); end
      checks++; if (wp.core_stall !== e_stall || wp.aux_ready !== e_ready || fifo_count !== CW'(e_count)) begin
        errors++; $display("FAIL rnd_ctl cyc %0d got stall=%0b ready=%0b count=%0d want %0b/%0b/%0d", n,
                           wp.core_stall, wp.aux_ready, fifo_count, e_stall, e_ready, e_count); end
      checks++; if (rs_pending !== e_rsp || rt_pending !== e_rtp) begin
        errors++; $display("FAIL rnd_sb cyc %0d got %0b/%0b want %0b/%0b", n,
                           rs_pending, rt_pending, e_rsp, e_rtp); end
      step();
    end
  endtask

  initial begin
    wp.core_we = 1'b0; wp.core_waddr = '0; wp.core_wdata = '0;
    wp.aux_valid = 1'b0; wp.aux_waddr = '0; wp.aux_wdata = '0;
    @(negedge clock);
    test_reset();
    test_single_push();
    test_starvation();
    test_full();
    test_invalidate();
    test_scoreboard();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
